uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx transmitter between NUM_CLIENTS byte producers using round-robin arbitration.
//  Grant is locked per message (i_last marks the final byte), so messages never interleave.
//  Lock is bounded by MAX_BURST bytes and by HOLD_TIMEOUT idle cycles.
//  Sits between client logic (debug console, log engine, bus-side UART_DR path) and uart_tx i_data_valid/i_data/o_busy.
// PARAMETERS
//  NUM_CLIENTS   4    number of requesters (>=2)
//  DATA_BITS     8    byte width; matches uart_tx DATA_BITS
//  MAX_BURST     16   max bytes per grant before forced rotation; 0 = unlimited
//  HOLD_TIMEOUT  1024 cycles a locked grant waits for the next byte before release; 0 = never release
// PORTS
//  clk         in  1                      clock
//  n_rst       in  1                      reset, asynchronous, active-low
//  i_req       in  NUM_CLIENTS            per-client byte request; i_data/i_last held stable until o_ack
//  i_last      in  NUM_CLIENTS            byte presented is final byte of message
//  i_data      in  NUM_CLIENTS*DATA_BITS  client k byte at [k*DATA_BITS +: DATA_BITS]
//  o_ack       out NUM_CLIENTS            one-cycle pulse: client byte consumed
//  o_grant     out NUM_CLIENTS            one-hot current owner; 0 when idle
//  o_active    out 1                      grant held (state != IDLE)
//  o_tx_valid  out 1                      byte valid to uart_tx (i_data_valid)
//  o_tx_data   out DATA_BITS              byte to uart_tx (i_data)
//  i_tx_busy   in  1                      uart_tx o_busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = NUM_CLIENTS-1 (client 0 highest first), counters 0.
//  Reset is async; it discards any held byte and drops o_tx_valid immediately.
//  FSM: IDLE, LOAD, SEND, GAP, HOLD.
//  IDLE: if |i_req, pick first requester searching from ptr+1 mod N (wrapping); register o_grant -> LOAD.
//  LOAD: if i_req[g]: o_ack[g]=1 this cycle; capture i_data[g] into o_tx_data and i_last[g] into last_q;
//        burst_cnt++ -> SEND. If i_req[g] has dropped: no ack, release -> IDLE.
//  SEND: o_tx_valid=1, o_tx_data stable. Byte accepted on the edge where i_tx_busy==0 -> GAP.
//        Busy high: hold indefinitely.
//  GAP: one cycle with o_tx_valid=0, giving uart_tx time to raise o_busy. Next state:
//        release if last_q, or if MAX_BURST!=0 and burst_cnt==MAX_BURST;
//        else LOAD if i_req[g]; else HOLD.
//  HOLD: LOAD when i_req[g]; hold_cnt++ each cycle. Release when hold_cnt==HOLD_TIMEOUT-1 (HOLD_TIMEOUT!=0).
//  Release: ptr<=g, o_grant<=0, burst_cnt<=0, hold_cnt<=0 -> IDLE.
//        Next arbitration happens in the IDLE cycle after release; releasing client is lowest priority.
//  Latency: req seen in IDLE at edge k -> LOAD (ack) in cycle k+1 -> o_tx_valid from cycle k+2.
//        Unbusy single-byte message: 4 cycles IDLE->IDLE.
//  Throughput limit: 1 byte per 3 cycles (LOAD, SEND, GAP); uart_tx baud dominates.
//  Counter widths: burst_cnt = $clog2(MAX_BURST+1), hold_cnt = $clog2(HOLD_TIMEOUT+1). Never wrap; cleared on release.
//  o_ack is at most one-hot, only in LOAD. o_tx_valid only in SEND.
//  o_active = (state != IDLE). o_grant is one-hot in every non-IDLE state.
//  Requests from non-owners are ignored while locked; no ack, no loss. They must keep i_req high.
//  Forced rotation (MAX_BURST) may split a message; the remainder is sent on a later grant.
// TESTING
//  1 client1 req 0xA5 last=1, busy=0 -> ack[1] at k+1, o_tx_valid=1 with 0xA5 for exactly cycle k+2, o_grant=0 at k+4.
//  2 clients 0,2 hold single-byte last=1 reqs continuously -> tx order 0,2,0,2,...; client 1/3 never acked.
//  3 client1 sends 0x11,0x22,0x33(last) while client3 requests 0x44 -> tx 0x11,0x22,0x33,0x44, no interleave.
//  4 MAX_BURST=16, client0 streams 20 bytes last=0, client1 waiting -> after 16th byte grant moves to client1.
//  5 busy held high 100 cycles in SEND -> o_tx_valid/o_tx_data stable, no o_ack; accepted on first busy=0 edge.
//  6 HOLD_TIMEOUT=8, client2 sends non-last byte then drops req -> release after 8 HOLD cycles, o_active=0.
//    n_rst asserted during SEND -> all outputs 0 asynchronously; client0 granted first after reset.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one uart_tx between NUM_CLIENTS byte producers; grant locked per message.
// Latency: req in IDLE -> ack next cycle -> tx_valid the cycle after. Backpressure: SEND waits on i_tx_busy.
module uart_tx_arbiter #(
  parameter int NUM_CLIENTS  = 4,
  parameter int DATA_BITS    = 8,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [NUM_CLIENTS-1:0]           i_req,
  input  logic [NUM_CLIENTS-1:0]           i_last,
  input  logic [NUM_CLIENTS*DATA_BITS-1:0] i_data,
  output logic [NUM_CLIENTS-1:0]           o_ack,
  output logic [NUM_CLIENTS-1:0]           o_grant,
  output logic                             o_active,
  output logic                             o_tx_valid,
  output logic [DATA_BITS-1:0]             o_tx_data,
  input  logic                             i_tx_busy
);

  localparam int PW = $clog2(NUM_CLIENTS);
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int HW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] PTR_RST   = PW'(NUM_CLIENTS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   last_q, last_d;
  logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;

  logic                   pick_vld;
  logic [PW-1:0]          pick_idx;
  logic [PW:0]            pick_sum;
  logic                   sel_req;
  logic                   sel_last;
  logic [DATA_BITS-1:0]   sel_data;
  logic                   rel;

  // Search starts one past the last owner, so the releasing client is lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_sum = '0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      pick_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (pick_sum >= (PW+1)'(NUM_CLIENTS)) begin
        pick_sum = pick_sum - (PW+1)'(NUM_CLIENTS);
      end
      if (!pick_vld && i_req[pick_sum[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = pick_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_req  = i_req[gidx_q];
    sel_last = i_last[gidx_q];
    sel_data = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (gidx_q == PW'(k)) begin
        sel_data = i_data[k*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      gidx_q      <= '0;
      ptr_q       <= PTR_RST;
      data_q      <= '0;
      last_q      <= 1'b0;
      burst_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rel         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gidx_d  = pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (sel_req) begin
          data_d  = sel_data;
          last_d  = sel_last;
          state_d = SEND;
          if (MAX_BURST != 0) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end else begin
          rel = 1'b1;
        end
      end
      SEND: begin
        if (!i_tx_busy) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (last_q || ((MAX_BURST != 0) && (burst_cnt_q == BURST_MAX))) begin
          rel = 1'b1;
        end else if (sel_req) begin
          state_d = LOAD;
        end else begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (sel_req) begin
          state_d    = LOAD;
          hold_cnt_d = '0;
        end else if (HOLD_TIMEOUT != 0) begin
          if (hold_cnt_q == HOLD_LAST) begin
            rel = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      ptr_d       = gidx_q;
      burst_cnt_d = '0;
      hold_cnt_d  = '0;
      state_d     = IDLE;
    end
  end

  always_comb begin
    o_active   = (state_q != IDLE);
    o_tx_valid = (state_q == SEND);
    o_grant    = '0;
    o_ack      = '0;
    if (state_q != IDLE) begin
      o_grant = NUM_CLIENTS'(1) << gidx_q;
    end
    if ((state_q == LOAD) && sel_req) begin
      o_ack = NUM_CLIENTS'(1) << gidx_q;
    end
  end

  assign o_tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: queue-driven client model plus a scoreboard of expected (client, byte) transmissions.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DB = 8;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic [N-1:0]    i_req = '0;
  logic [N-1:0]    i_last = '0;
  logic [N*DB-1:0] i_data = '0;
  logic            i_tx_busy = 1'b0;
  logic [N-1:0]    o_ack;
  logic [N-1:0]    o_grant;
  logic            o_active;
  logic            o_tx_valid;
  logic [DB-1:0]   o_tx_data;

  uart_tx_arbiter #(.NUM_CLIENTS(N), .DATA_BITS(DB), .MAX_BURST(16), .HOLD_TIMEOUT(8)) dut (
    .clk(clk), .n_rst(n_rst), .i_req(i_req), .i_last(i_last), .i_data(i_data),
    .o_ack(o_ack), .o_grant(o_grant), .o_active(o_active), .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] cl; logic [7:0] dat; logic last; } stim_t;
  typedef struct packed { logic [1:0] cl; logic [7:0] dat; } exp_t;

  stim_t pend[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    ack_tot[N];
  int    pop_tot[N];

  function automatic int find_first(int k);
    for (int j = 0; j < pend.size(); j++) begin
      if (int'(pend[j].cl) == k) return j;
    end
    return -1;
  endfunction

  // Client model: each client presents its oldest pending byte until it has been acked.
  always @(posedge clk) begin : drv
    int j;
    #1;
    for (int k = 0; k < N; k++) begin
      while (pop_tot[k] < ack_tot[k]) begin
        j = find_first(k);
        if (j >= 0) pend.delete(j);
        pop_tot[k]++;
      end
      j = find_first(k);
      i_req[k]          = (j >= 0);
      i_last[k]         = (j >= 0) ? pend[j].last : 1'b0;
      i_data[k*DB +: DB] = (j >= 0) ? pend[j].dat : 8'h00;
    end
  end

  // Monitor: protocol sanity each cycle and scoreboard pop on every accepted byte.
  always @(negedge clk) begin : mon
    exp_t e;
    int   gcl;
    if (n_rst) begin
      for (int k = 0; k < N; k++) if (o_ack[k]) ack_tot[k]++;
      n_checks++;
      if (((o_ack & ~o_grant) != '0) || ($countones(o_ack) > 1) || (o_tx_valid && o_ack != '0)) begin
        n_fail++;
        $display("FAIL ack_onehot: ack=%b grant=%b tx_valid=%b, required ack one-hot within grant and not in SEND",
                 o_ack, o_grant, o_tx_valid);
      end
      if (o_tx_valid && !i_tx_busy) begin
        gcl = 0;
        for (int k = 0; k < N; k++) if (o_grant[k]) gcl = k;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got client %0d byte %h, required no transmission", gcl, o_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (o_tx_data !== e.dat || gcl != int'(e.cl)) begin
            n_fail++;
            $display("FAIL tx_order: got client %0d byte %h, required client %0d byte %h",
                     gcl, o_tx_data, e.cl, e.dat);
          end
        end
      end
    end
  end

  task automatic do_reset();
    n_rst = 1'b0;
    i_tx_busy = 1'b0;
    pend.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
  endtask

  task automatic push(input int cl, input logic [7:0] dat, input logic last, input logic expect_tx);
    pend.push_back('{cl: 2'(cl), dat: dat, last: last});
    if (expect_tx) exp_q.push_back('{cl: 2'(cl), dat: dat});
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || pend.size() != 0 || o_active) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c >= 1000) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still expected, active=%b after 1000 cycles, required 0", name, exp_q.size(), o_active);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_ack, o_grant, o_active, o_tx_valid, o_tx_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b grant=%b active=%b valid=%b data=%h, required all 0",
               o_ack, o_grant, o_active, o_tx_valid, o_tx_data);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    push(1, 8'hA5, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if (i_req[1] !== 1'b1 || o_active !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: req1=%b active=%b, required 1 and 0", i_req[1], o_active);
    end
    @(negedge clk);
    n_checks++;
    if (o_ack !== 4'b0010 || o_grant !== 4'b0010 || o_tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_load: ack=%b grant=%b valid=%b, required 0010 0010 0", o_ack, o_grant, o_tx_valid);
    end
    @(negedge clk);
    n_checks++;
    if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_send: valid=%b data=%h, required 1 a5", o_tx_valid, o_tx_data);
    end
    @(negedge clk);
    n_checks++;
    if (o_tx_valid !== 1'b0 || o_active !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gap: valid=%b active=%b, required 0 1", o_tx_valid, o_active);
    end
    @(negedge clk);
    n_checks++;
    if (o_grant !== 4'b0000 || o_active !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: grant=%b active=%b, required 0000 0", o_grant, o_active);
    end
    wait_drain("single");
  endtask

  task automatic test_round_robin();
    int a1, a3;
    do_reset();
    a1 = ack_tot[1];
    a3 = ack_tot[3];
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      push(0, 8'(8'h10 + i), 1'b1, 1'b1);
      push(2, 8'(8'h20 + i), 1'b1, 1'b1);
    end
    wait_drain("rr");
    n_checks++;
    if (ack_tot[1] != a1 || ack_tot[3] != a3) begin
      n_fail++;
      $display("FAIL rr_idle_clients: acks to 1/3 = %0d/%0d, required 0/0", ack_tot[1] - a1, ack_tot[3] - a3);
    end
  endtask

  task automatic test_message_lock();
    do_reset();
    @(negedge clk);
    push(1, 8'h11, 1'b0, 1'b1);
    push(1, 8'h22, 1'b0, 1'b1);
    push(1, 8'h33, 1'b1, 1'b1);
    push(3, 8'h44, 1'b1, 1'b1);
    wait_drain("msg_lock");
  endtask

  task automatic test_burst_limit();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 20; i++) pend.push_back('{cl: 2'd0, dat: 8'(i), last: 1'b0});
    push(1, 8'hC1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back('{cl: 2'd0, dat: 8'(i)});
    exp_q.push_back('{cl: 2'd1, dat: 8'hC1});
    for (int i = 16; i < 20; i++) exp_q.push_back('{cl: 2'd0, dat: 8'(i)});
    wait_drain("burst");
  endtask

  task automatic test_busy_stall();
    int c = 0;
    do_reset();
    i_tx_busy = 1'b1;
    @(negedge clk);
    push(1, 8'h5A, 1'b1, 1'b1);
    while (!o_tx_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c >= 20) begin
      n_fail++;
      $display("FAIL busy_reach_send: tx_valid=%b after 20 cycles, required 1", o_tx_valid);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h5A || o_ack !== 4'b0000) begin
        n_fail++;
        $display("FAIL busy_hold: cycle %0d valid=%b data=%h ack=%b, required 1 5a 0000", i, o_tx_valid, o_tx_data, o_ack);
      end
    end
    @(posedge clk);
    #2 i_tx_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (o_tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_accept: valid=%b one cycle after busy drop, required 0", o_tx_valid);
    end
    wait_drain("busy");
  endtask

  task automatic test_hold_timeout();
    int c = 0;
    int act = 1;
    do_reset();
    @(negedge clk);
    push(2, 8'h77, 1'b0, 1'b1);
    while (!(o_tx_valid && !i_tx_busy) && c < 20) begin
      @(negedge clk);
      c++;
    end
    while (o_active && act < 50) begin
      @(negedge clk);
      if (o_active) act++;
    end
    n_checks++;
    if (act != 10) begin
      n_fail++;
      $display("FAIL hold_timeout: active cycles from SEND = %0d, required 10 (SEND+GAP+8 HOLD)", act);
    end
    n_checks++;
    if (o_active !== 1'b0 || o_grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL hold_release: active=%b grant=%b, required 0 0000", o_active, o_grant);
    end
    wait_drain("hold");
  endtask

  task automatic test_reset_in_send();
    int c = 0;
    do_reset();
    i_tx_busy = 1'b1;
    @(negedge clk);
    push(3, 8'h99, 1'b1, 1'b0);
    while (!o_tx_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    #2 n_rst = 1'b0;
    #1;
    n_checks++;
    if ({o_ack, o_grant, o_active, o_tx_valid, o_tx_data} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ack=%b grant=%b active=%b valid=%b data=%h, required all 0",
               o_ack, o_grant, o_active, o_tx_valid, o_tx_data);
    end
    pend.delete();
    exp_q.delete();
    i_tx_busy = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b1;
    push(2, 8'hB2, 1'b1, 1'b0);
    push(0, 8'hB0, 1'b1, 1'b1);
    exp_q.push_back('{cl: 2'd2, dat: 8'hB2});
    c = 0;
    @(negedge clk);
    while (!o_active && c < 10) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (o_grant !== 4'b0001 || o_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b ack=%b, required 0001 0001", o_grant, o_ack);
    end
    wait_drain("post_reset");
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      ack_tot[k] = 0;
      pop_tot[k] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_message_lock();
    test_burst_limit();
    test_busy_stall();
    test_hold_timeout();
    test_reset_in_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
